mdu_sequencer: RTL and testbench
================================

Name: mdu_sequencer

Overview:
Multi-cycle multiply/divide sequencer sitting beside the execute stage; it accepts one MULT/MULTU/DIV/DIVU from E and runs it to completion.
- Radix-2 restoring divider: 32 iterations.
- Multiplier: fixed-latency, depth set by parameter.
- Raises a pipeline stall request while the operation is in flight.
- Presents the registered {hi,lo} result for the M-stage HILO write.
- Cancels cleanly on exception flush.

Parameters:
- MUL_LAT, 2, multiply cycles after acceptance (range 1..8).
- DIV_ITERS, 32, divider iterations; fixed at 32 for MIPS32.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start_i  in  1  E-stage instruction is a mul/div op (mulOrdiv && mdToHilo, valid).
- is_div_i  in  1  1 = divide, 0 = multiply.
- is_sign_i  in  1  signed operation (mdIsSign).
- a_i  in  32  rs operand (dividend / multiplicand).
- b_i  in  32  rt operand (divisor / multiplier).
- flush_i  in  1  exception flush of E; abort the current op.
- pipe_stall_i  in  1  stall of E from other sources.
- stall_req_o  out  1  request to stall F/D/E.
- busy_o  out  1  op in flight (MUL or DIV state).
- done_o  out  1  result valid this cycle (DONE state).
- hi_o  out  32  remainder / product[63:32].
- lo_o  out  32  quotient / product[31:0].

Behaviour:
- Reset (async): state=IDLE, counter=0, hi_o=lo_o=0, done_o=busy_o=stall_req_o=0.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - start_i && !flush_i → latch operands and sign info.
  - Go to DIV (is_div_i) or MUL; counter=0.
- stall_req_o = (IDLE && start_i && !flush_i) || MUL || DIV. It is combinational, so it is high in the accept cycle.
- MUL:
  - Product = signed/unsigned 64-bit of the latched operands, computed in the accept cycle and delayed.
  - After MUL_LAT cycles go to DONE with {hi_o,lo_o}=product.
  - Total stall = MUL_LAT+1 cycles.
- DIV:
  - Operates on magnitudes (two's-complement negate when signed and negative).
  - One restoring step per cycle; after DIV_ITERS cycles go to DONE.
  - Sign fix: quotient negated if signs differ; remainder takes the dividend's sign.
  - Total stall = 33 cycles.
- Divide by zero: lo_o=0xFFFFFFFF and hi_o=a_i (raw), regardless of is_sign_i.
- Signed special case: 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DONE:
  - done_o=1, stall_req_o=0.
  - Stays in DONE while pipe_stall_i=1, so a still-resident instruction is not restarted.
  - Goes to IDLE when pipe_stall_i=0. start_i is ignored in DONE.
- hi_o/lo_o are registered and hold their value until the next op completes.
- flush_i in any state → IDLE at the next edge, with no done_o pulse.
  - hi_o/lo_o keep their old value; stall_req_o drops immediately (combinational mask).
  - A flush coincident with start_i is not accepted.
- Back-to-back ops: an op in E the cycle after DONE→IDLE is accepted normally.

Optional Feature:
- Macro: MDU_DIV_EARLY_OUT_EN.
- Defined: in the accept cycle, a divisor of 0 or |a| < |b| goes directly to DONE. Results: divide-by-zero values as above, or q=0, r=a_i. Stall is 1 cycle.
- Undefined: every divide takes the full 32 iterations.
- Results are identical in both cases.

Decomposition:
- Shared package mdu_pkg: state encoding enum (IDLE/MUL/DIV/DONE), DIV_ITERS=32, DIV0_LO=32'hFFFFFFFF.
- Sub-module div_radix2_core:
  - Holds the remainder/quotient shift registers and the per-iteration subtract step.
  - Controls: load, step; magnitude inputs; raw q/r outputs.
  - Sign fix-up stays in the sequencer.

Test Plan:
- DIVU a=100, b=7 → stall_req_o high 33 cycles; done_o next cycle; lo=14, hi=2.
- DIV a=-7 (0xFFFFFFF9), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV a=7, b=-2 → lo=0xFFFFFFFD, hi=1.
- MULT a=0xFFFFFFFF, b=2, MUL_LAT=2 → stall 3 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands → hi=1, lo=0xFFFFFFFE.
- DIVU b=0, a=0x1234 → lo=0xFFFFFFFF, hi=0x1234. With MDU_DIV_EARLY_OUT_EN: stall 1 cycle.
- DIV started, flush_i at iteration 10 → IDLE next cycle; done_o never pulses; hi/lo keep the prior result; stall_req_o low that cycle.
- MULTU done with pipe_stall_i=1 for 3 cycles and start_i held high → stays in DONE, no restart, exactly one result. Second MULTU the cycle after release → accepted.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: definitions shared by the multiply/divide sequencer and its
// divider core.
//   mduState_t - sequencer state encoding (IDLE / MUL / DIV / DONE)
//   DIV_ITERS  - restoring divider iteration count for 32-bit operands
//   DIV0_LO    - quotient reported for a divide by zero
//   negIf()    - conditional two's-complement negate
package mdu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } mduState_t;

  localparam int          DIV_ITERS = 32;
  localparam logic [31:0] DIV0_LO   = 32'hFFFF_FFFF;

  function automatic logic [31:0] negIf(input logic [31:0] value, input logic neg);
    return neg ? (~value + 32'd1) : value;
  endfunction

endpackage

// File: rtl/div_radix2_core.sv
// div_radix2_core: unsigned radix-2 restoring divider datapath.
// Holds the partial-remainder and quotient shift registers and performs one
// compare/subtract step per cycle while step is high. Sign handling is done
// by the caller; this core only sees magnitudes.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   load               capture dividend/divisor, clear partial remainder
//   step               perform one restoring iteration
//   dividend, divisor  unsigned magnitudes
//   quotient           raw quotient after the step of the current cycle
//   remainder          raw remainder after the step of the current cycle
module div_radix2_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] quoReg;
  logic [31:0] remReg;
  logic [31:0] divReg;
  logic [32:0] shifted;
  logic [32:0] diff;

  // The quotient register doubles as the dividend shifter: its MSB is shifted
  // into the partial remainder and the new quotient bit enters at the LSB.
  // Outputs are the post-step values so the caller can capture the final
  // result on the same edge as the last iteration.
  always_comb begin
    shifted = {remReg, quoReg[31]};
    diff    = shifted - {1'b0, divReg};
    if (!diff[32]) begin
      remainder = diff[31:0];
      quotient  = {quoReg[30:0], 1'b1};
    end else begin
      remainder = shifted[31:0];
      quotient  = {quoReg[30:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quoReg <= '0;
      remReg <= '0;
      divReg <= '0;
    end else if (load) begin
      quoReg <= dividend;
      remReg <= '0;
      divReg <= divisor;
    end else if (step) begin
      quoReg <= quotient;
      remReg <= remainder;
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle MULT/MULTU/DIV/DIVU sequencer beside the
// execute stage. Accepts one op from E, stalls the front of the pipe while
// it runs, and presents a registered {hi,lo} for the M-stage HILO write.
// Optional build macro: MDU_DIV_EARLY_OUT_EN - divides with a zero divisor or
// |a| < |b| finish in the accept cycle instead of iterating.
// Parameters:
//   MUL_LAT    multiply cycles after acceptance (1..8)
//   DIV_ITERS  divider iterations (32)
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start_i       E-stage mul/div op present
//   is_div_i      1 = divide, 0 = multiply
//   is_sign_i     signed operation
//   a_i, b_i      rs / rt operands
//   flush_i       exception flush of E, aborts the op
//   pipe_stall_i  E held by another source
//   stall_req_o   stall F/D/E
//   busy_o        op in flight (MUL or DIV)
//   done_o        result valid (DONE)
//   hi_o, lo_o    remainder/product high, quotient/product low
//   stateDbg_o    current sequencer state
module mdu_sequencer
  import mdu_pkg::mduState_t;
  import mdu_pkg::S_IDLE;
  import mdu_pkg::S_MUL;
  import mdu_pkg::S_DIV;
  import mdu_pkg::S_DONE;
  import mdu_pkg::DIV0_LO;
  import mdu_pkg::negIf;
#(
  parameter int MUL_LAT   = 2,
  parameter int DIV_ITERS = mdu_pkg::DIV_ITERS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        is_div_i,
  input  logic        is_sign_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  input  logic        pipe_stall_i,
  output logic        stall_req_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output mduState_t   stateDbg_o
);

  localparam logic [5:0] MUL_LAST = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_LAST = 6'(DIV_ITERS - 1);

  mduState_t   state;
  mduState_t   stateNext;
  logic [5:0]  counter;
  logic [63:0] product;
  logic        signQ;
  logic        signR;
  logic        divZero;
  logic [31:0] aRaw;

  logic        accept;
  logic        mulLast;
  logic        divLast;
  logic        earlyOut;
  logic [31:0] aMag;
  logic [31:0] bMag;
  logic [63:0] aExt;
  logic [63:0] bExt;
  logic [63:0] prodFull;
  logic [31:0] coreQ;
  logic [31:0] coreR;

  assign aMag = negIf(a_i, is_sign_i & a_i[31]);
  assign bMag = negIf(b_i, is_sign_i & b_i[31]);

  // The low 64 bits of a product of 64-bit extended operands are the same for
  // signed and unsigned arithmetic, so only the extension differs.
  assign aExt     = {{32{is_sign_i & a_i[31]}}, a_i};
  assign bExt     = {{32{is_sign_i & b_i[31]}}, b_i};
  assign prodFull = aExt * bExt;

`ifdef MDU_DIV_EARLY_OUT_EN
  // Quotient is trivially 0 (or the div-by-zero pattern) in these cases.
  assign earlyOut = is_div_i && ((b_i == '0) || (aMag < bMag));
`else
  assign earlyOut = 1'b0;
`endif

  div_radix2_core u_divCore (
    .clk       (clk),
    .rst       (rst),
    .load      (accept && is_div_i),
    .step      ((state == S_DIV) && !flush_i),
    .dividend  (aMag),
    .divisor   (bMag),
    .quotient  (coreQ),
    .remainder (coreR)
  );

  // Handshake with E: an op is taken in the cycle start_i is high in IDLE
  // with no flush; stall_req_o rises combinationally in that same cycle and
  // stays high through MUL/DIV, so E holds the instruction until DONE. In
  // DONE the instruction may still sit in E (pipe_stall_i), so start_i is
  // ignored until the sequencer has returned to IDLE.
  always_comb begin
    stateNext   = state;
    accept      = 1'b0;
    mulLast     = 1'b0;
    divLast     = 1'b0;
    stall_req_o = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          accept      = 1'b1;
          stall_req_o = 1'b1;
          if (earlyOut)      stateNext = S_DONE;
          else if (is_div_i) stateNext = S_DIV;
          else               stateNext = S_MUL;
        end
      end
      S_MUL: begin
        stall_req_o = !flush_i;
        if (counter == MUL_LAST) begin
          mulLast   = 1'b1;
          stateNext = S_DONE;
        end
      end
      S_DIV: begin
        stall_req_o = !flush_i;
        if (counter == DIV_LAST) begin
          divLast   = 1'b1;
          stateNext = S_DONE;
        end
      end
      S_DONE: begin
        if (!pipe_stall_i) stateNext = S_IDLE;
      end
      default: stateNext = S_IDLE;
    endcase
    // A flush abandons the op without touching the result registers.
    if (flush_i) begin
      stateNext = S_IDLE;
      mulLast   = 1'b0;
      divLast   = 1'b0;
    end
  end

  assign busy_o     = (state == S_MUL) || (state == S_DIV);
  assign done_o     = (state == S_DONE);
  assign stateDbg_o = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      counter <= '0;
      product <= '0;
      signQ   <= 1'b0;
      signR   <= 1'b0;
      divZero <= 1'b0;
      aRaw    <= '0;
      hi_o    <= '0;
      lo_o    <= '0;
    end else begin
      state <= stateNext;

      if (accept || flush_i) begin
        counter <= '0;
      end else if (busy_o) begin
        counter <= counter + 6'd1;
      end

      if (accept) begin
        product <= prodFull;
        signQ   <= is_sign_i & (a_i[31] ^ b_i[31]);
        signR   <= is_sign_i & a_i[31];
        divZero <= (b_i == '0);
        aRaw    <= a_i;
      end

      if (accept && earlyOut) begin
        hi_o <= a_i;
        lo_o <= (b_i == '0) ? DIV0_LO : 32'd0;
      end else if (mulLast) begin
        hi_o <= product[63:32];
        lo_o <= product[31:0];
      end else if (divLast) begin
        if (divZero) begin
          hi_o <= aRaw;
          lo_o <= DIV0_LO;
        end else begin
          // Quotient sign follows the operand signs, remainder the dividend.
          hi_o <= negIf(coreR, signR);
          lo_o <= negIf(coreQ, signQ);
        end
      end
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
module tb_mdu_sequencer;
  import mdu_pkg::*;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        is_div_i;
  logic        is_sign_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        flush_i;
  logic        pipe_stall_i;
  logic        stall_req_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  mduState_t   stateDbg_o;

  always #5 clk = ~clk;

  mdu_sequencer #(.MUL_LAT(MUL_LAT), .DIV_ITERS(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .is_div_i     (is_div_i),
    .is_sign_i    (is_sign_i),
    .a_i          (a_i),
    .b_i          (b_i),
    .flush_i      (flush_i),
    .pipe_stall_i (pipe_stall_i),
    .stall_req_o  (stall_req_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o),
    .stateDbg_o   (stateDbg_o)
  );

  int          checks = 0;
  int          errors = 0;
  int          doneCount = 0;
  logic        donePrev = 1'b0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic        isDiv;
    logic        isSign;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] expHiLo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference results from plain integer arithmetic.
  function automatic logic [63:0] model(input logic isDiv, input logic isSign,
                                        input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    int              ia, ib, q, r;
    if (!isDiv) begin
      if (isSign) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
      end
      ua = {32'd0, a};
      ub = {32'd0, b};
      return ua * ub;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (isSign) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      ia = a;
      ib = b;
      q  = ia / ib;
      r  = ia % ib;
      return {r, q};
    end
    return {a % b, a / b};
  endfunction

  function automatic int expStall(input logic isDiv, input logic isSign,
                                  input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    if (!isDiv) return MUL_LAT + 1;
    ma = (isSign && a[31]) ? -a : a;
    mb = (isSign && b[31]) ? -b : b;
`ifdef MDU_DIV_EARLY_OUT_EN
    if (b == 32'd0 || ma < mb) return 1;
`else
    if (ma == mb + 32'd1) return 33;  // keeps ma/mb used; same count either way
`endif
    return 33;
  endfunction

  // Scoreboard: compare on the first cycle of each done_o pulse.
  always @(negedge clk) begin
    if (!rst && done_o && !donePrev) begin
      doneCount++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got %h with no result expected", {hi_o, lo_o});
      end else begin
        checks--;
        check("result", {hi_o, lo_o}, exp_q.pop_front());
      end
    end
    donePrev <= done_o;
  end

  task automatic waitDone(input string name);
    int cyc = 0;
    while (!done_o && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!done_o) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done_o within %0d cycles, required done_o", name, cyc);
    end
  endtask

  task automatic runOp(input logic isDiv, input logic isSign, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp, input string name);
    int stallCnt;
    int cyc;
    @(negedge clk);
    start_i   = 1'b1;
    is_div_i  = isDiv;
    is_sign_i = isSign;
    a_i       = a;
    b_i       = b;
    exp_q.push_back(exp);
    #2;
    stallCnt = stall_req_o ? 1 : 0;
    @(posedge clk); #1;
    start_i = 1'b0;
    a_i     = $urandom;
    b_i     = $urandom;
    cyc     = 0;
    while (!done_o && cyc < 100) begin
      if (stall_req_o) stallCnt++;
      @(posedge clk); #1;
      cyc++;
    end
    if (!done_o) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done_o within %0d cycles, required done_o", name, cyc);
    end
    check({name, "_stall"}, 64'(stallCnt), 64'(expStall(isDiv, isSign, a, b)));
    @(posedge clk); #1;
    check({name, "_done_drop"}, {63'd0, done_o}, 64'd0);
    check({name, "_hold"}, {hi_o, lo_o}, exp);
  endtask

  vec_t vecs[12];

  initial begin
    int dc;
    logic        rd, rs;
    logic [31:0] ra, rb;

    vecs[0]  = '{1'b1, 1'b0, 32'd100,        32'd7,          {32'd2,          32'd14}};
    vecs[1]  = '{1'b1, 1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF,  32'hFFFF_FFFD}};
    vecs[2]  = '{1'b1, 1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1,          32'hFFFF_FFFD}};
    vecs[3]  = '{1'b0, 1'b1, 32'hFFFF_FFFF,  32'd2,          {32'hFFFF_FFFF,  32'hFFFF_FFFE}};
    vecs[4]  = '{1'b0, 1'b0, 32'hFFFF_FFFF,  32'd2,          {32'd1,          32'hFFFF_FFFE}};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_1234,  32'd0,          {32'h0000_1234,  32'hFFFF_FFFF}};
    vecs[6]  = '{1'b1, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0,          32'h8000_0000}};
    vecs[7]  = '{1'b1, 1'b1, 32'hFFFF_FF00,  32'd0,          {32'hFFFF_FF00,  32'hFFFF_FFFF}};
    vecs[8]  = '{1'b1, 1'b0, 32'd5,          32'd9,          {32'd5,          32'd0}};
    vecs[9]  = '{1'b1, 1'b1, 32'hFFFF_FFFB,  32'd9,          {32'hFFFF_FFFB,  32'd0}};
    vecs[10] = '{1'b0, 1'b1, 32'h8000_0000,  32'h8000_0000,  {32'h4000_0000,  32'd0}};
    vecs[11] = '{1'b1, 1'b0, 32'hFFFF_FFFF,  32'd1,          {32'd0,          32'hFFFF_FFFF}};

    // Clock/reset
    rst = 1'b1; start_i = 1'b0; is_div_i = 1'b0; is_sign_i = 1'b0;
    a_i = '0; b_i = '0; flush_i = 1'b0; pipe_stall_i = 1'b0;
    #12;
    check("reset_state", 64'(stateDbg_o), 64'(S_IDLE));
    check("reset_hilo", {hi_o, lo_o}, 64'd0);
    check("reset_flags", {61'd0, done_o, busy_o, stall_req_o}, 64'd0);
    @(negedge clk); rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 12; i++)
      runOp(vecs[i].isDiv, vecs[i].isSign, vecs[i].a, vecs[i].b, vecs[i].expHiLo,
            $sformatf("vec%0d", i));

    // Random ops against the integer model
    for (int i = 0; i < 10; i++) begin
      rd = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      runOp(rd, rs, ra, rb, model(rd, rs, ra, rb), $sformatf("rnd%0d", i));
    end

    // Flush in the middle of a divide
    runOp(1'b1, 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, "preflush");
    @(negedge clk);
    start_i = 1'b1; is_div_i = 1'b1; is_sign_i = 1'b1; a_i = 32'd1000; b_i = 32'd3;
    #2 check("flush_accept_stall", {63'd0, stall_req_o}, 64'd1);
    @(posedge clk); #1 start_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); flush_i = 1'b1;
    #1 check("flush_stall_mask", {63'd0, stall_req_o}, 64'd0);
    dc = doneCount;
    @(posedge clk); #1 flush_i = 1'b0;
    check("flush_state", 64'(stateDbg_o), 64'(S_IDLE));
    check("flush_busy", {63'd0, busy_o}, 64'd0);
    check("flush_hilo_kept", {hi_o, lo_o}, {32'd2, 32'd14});
    repeat (40) @(posedge clk);
    #1 check("flush_no_done", 64'(doneCount), 64'(dc));

    // Flush coincident with start is not accepted
    @(negedge clk);
    start_i = 1'b1; flush_i = 1'b1; is_div_i = 1'b0; a_i = 32'd3; b_i = 32'd4;
    #1 check("flush_start_stall", {63'd0, stall_req_o}, 64'd0);
    @(posedge clk); #1 start_i = 1'b0; flush_i = 1'b0;
    check("flush_start_state", 64'(stateDbg_o), 64'(S_IDLE));

    // DONE held by pipe_stall_i with start_i high, then back-to-back MULTU
    @(negedge clk);
    exp_q.push_back(model(1'b0, 1'b0, 32'd12345, 32'd678));
    start_i = 1'b1; is_div_i = 1'b0; is_sign_i = 1'b0; a_i = 32'd12345; b_i = 32'd678;
    pipe_stall_i = 1'b1;
    dc = doneCount;
    @(posedge clk); #1;
    waitDone("hold1");
    for (int i = 0; i < 3; i++) begin
      check($sformatf("hold_state%0d", i), 64'(stateDbg_o), 64'(S_DONE));
      check($sformatf("hold_stall%0d", i), {63'd0, stall_req_o}, 64'd0);
      if (i == 2) begin
        pipe_stall_i = 1'b0;
        a_i = 32'hDEAD_BEEF; b_i = 32'h0001_0001;
        exp_q.push_back(model(1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0001_0001));
      end
      @(posedge clk); #1;
    end
    check("hold_one_result", 64'(doneCount), 64'(dc + 1));
    check("b2b_accept", {63'd0, stall_req_o}, 64'd1);
    @(posedge clk); #1 start_i = 1'b0;
    waitDone("b2b");
    @(posedge clk); #1;
    check("b2b_two_results", 64'(doneCount), 64'(dc + 2));

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    start_i = 1'b1; is_div_i = 1'b1; a_i = 32'd99; b_i = 32'd5;
    @(posedge clk); #1 start_i = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst_busy", {63'd0, busy_o}, 64'd0);
    check("async_rst_hilo", {hi_o, lo_o}, 64'd0);
    check("async_rst_state", 64'(stateDbg_o), 64'(S_IDLE));
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog");
  end

endmodule
